// File: rtl/dec_syndrome_corrector.sv
// Pipelined SECDED syndrome decoder and single-bit corrector with valid/ready flow control.
// Stage 1 registers the word and its syndrome; stage 2 registers the classification and corrected word.
module dec_syndrome_corrector #(
  parameter int CODE_WIDTH = 32,
  parameter int SYN_WIDTH  = $clog2(CODE_WIDTH) + 1,
  parameter bit CORRECT_EN = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_WIDTH-1:0] codeword_with_errors,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CODE_WIDTH-1:0] corrected_codeword,
  output logic [SYN_WIDTH-1:0]  mul_result,
  output logic                  err_single,
  output logic                  err_double,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  cnt_corr,
  output logic [CNT_WIDTH-1:0]  cnt_uncorr
);

  localparam int POS_W = SYN_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CODE_WIDTH-1:0] ONE_HOT0 = {{(CODE_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    CLS_NONE   = 2'b00,
    CLS_SINGLE = 2'b01,
    CLS_DOUBLE = 2'b10
  } cls_e;

  // {overall parity, XOR of the indices of all set bits above bit 0}
  function automatic logic [SYN_WIDTH-1:0] calc_syndrome(input logic [CODE_WIDTH-1:0] word);
    logic [POS_W-1:0] pos;
    pos = {POS_W{1'b0}};
    for (int i = 1; i < CODE_WIDTH; i++) begin
      pos = pos ^ (word[i] ? POS_W'(i) : {POS_W{1'b0}});
    end
    return {^word, pos};
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic [CODE_WIDTH-1:0] s1_word_q, s1_word_d;
  logic [SYN_WIDTH-1:0]  s1_syn_q, s1_syn_d;

  logic                  out_valid_q, out_valid_d;
  logic [CODE_WIDTH-1:0] corr_q, corr_d;
  logic [SYN_WIDTH-1:0]  syn_q, syn_d;
  logic                  single_q, single_d;
  logic                  double_q, double_d;
  logic [CNT_WIDTH-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_WIDTH-1:0]  cnt_uncorr_q, cnt_uncorr_d;

  logic                  advance_s;
  logic                  xfer_s;
  logic                  syn_par_s;
  logic [POS_W-1:0]      syn_pos_s;
  logic [CODE_WIDTH-1:0] flip_mask_s;
  logic                  pos_in_range_s;
  cls_e                  cls_s;
  logic [CODE_WIDTH-1:0] fixed_word_s;

  assign advance_s = !out_valid_q || out_ready;
  assign xfer_s    = out_valid_q && out_ready;

  // Stage-1 next state: a stall holds everything, an advance may load a bubble.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_word_d  = s1_word_q;
    s1_syn_d   = s1_syn_q;
    if (advance_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_word_d = codeword_with_errors;
        s1_syn_d  = calc_syndrome(codeword_with_errors);
      end else begin
        s1_word_d = s1_word_q;
        s1_syn_d  = s1_syn_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // A position beyond the word shifts the one-hot mask out entirely, which flags it as out of range.
  always_comb begin
    syn_par_s      = s1_syn_q[SYN_WIDTH-1];
    syn_pos_s      = s1_syn_q[POS_W-1:0];
    flip_mask_s    = ONE_HOT0 << syn_pos_s;
    pos_in_range_s = |flip_mask_s;
    case ({syn_par_s, (syn_pos_s != {POS_W{1'b0}})})
      2'b00:   cls_s = CLS_NONE;
      2'b10:   cls_s = CLS_SINGLE;
      2'b11:   cls_s = pos_in_range_s ? CLS_SINGLE : CLS_DOUBLE;
      2'b01:   cls_s = CLS_DOUBLE;
      default: cls_s = CLS_DOUBLE;
    endcase
    if (CORRECT_EN && (cls_s == CLS_SINGLE)) begin
      fixed_word_s = s1_word_q ^ flip_mask_s;
    end else begin
      fixed_word_s = s1_word_q;
    end
  end

  // Stage-2 next state: results only change when a real word moves in, so flags persist across bubbles.
  always_comb begin
    out_valid_d = out_valid_q;
    corr_d      = corr_q;
    syn_d       = syn_q;
    single_d    = single_q;
    double_d    = double_q;
    if (advance_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        corr_d   = fixed_word_s;
        syn_d    = s1_syn_q;
        single_d = (cls_s == CLS_SINGLE);
        double_d = (cls_s == CLS_DOUBLE);
      end else begin
        corr_d   = corr_q;
        syn_d    = syn_q;
        single_d = single_q;
        double_d = double_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Saturating statistics; a clear wins over a simultaneous increment.
  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (cnt_clr) begin
      cnt_corr_d   = {CNT_WIDTH{1'b0}};
      cnt_uncorr_d = {CNT_WIDTH{1'b0}};
    end else begin
      if (xfer_s && single_q && (cnt_corr_q != CNT_MAX)) begin
        cnt_corr_d = cnt_corr_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_corr_d = cnt_corr_q;
      end
      if (xfer_s && double_q && (cnt_uncorr_q != CNT_MAX)) begin
        cnt_uncorr_d = cnt_uncorr_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_uncorr_d = cnt_uncorr_q;
      end
    end
  end

  // Pipeline and counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_word_q    <= {CODE_WIDTH{1'b0}};
      s1_syn_q     <= {SYN_WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      corr_q       <= {CODE_WIDTH{1'b0}};
      syn_q        <= {SYN_WIDTH{1'b0}};
      single_q     <= 1'b0;
      double_q     <= 1'b0;
      cnt_corr_q   <= {CNT_WIDTH{1'b0}};
      cnt_uncorr_q <= {CNT_WIDTH{1'b0}};
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_word_q    <= s1_word_d;
      s1_syn_q     <= s1_syn_d;
      out_valid_q  <= out_valid_d;
      corr_q       <= corr_d;
      syn_q        <= syn_d;
      single_q     <= single_d;
      double_q     <= double_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign in_ready           = advance_s;
  assign out_valid          = out_valid_q;
  assign corrected_codeword = corr_q;
  assign mul_result         = syn_q;
  assign err_single         = single_q;
  assign err_double         = double_q;
  assign cnt_corr           = cnt_corr_q;
  assign cnt_uncorr         = cnt_uncorr_q;

endmodule

// File: tb/tb_dec_syndrome_corrector.sv
// Directed bench: four configurations driven from one stimulus stream, checked with immediate assertions.
module tb_dec_syndrome_corrector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [31:0] cw;

  logic        m_in_ready, m_out_valid, m_single, m_double;
  logic [31:0] m_corr;
  logic [5:0]  m_syn;
  logic [15:0] m_cnt_c, m_cnt_u;

  logic        n_in_ready, n_out_valid, n_single, n_double;
  logic [31:0] n_corr;
  logic [5:0]  n_syn;
  logic [15:0] n_cnt_c, n_cnt_u;

  logic        c_in_ready, c_out_valid, c_single, c_double;
  logic [31:0] c_corr;
  logic [5:0]  c_syn;
  logic [1:0]  c_cnt_c, c_cnt_u;

  logic        w_in_ready, w_out_valid, w_single, w_double;
  logic [11:0] w_corr;
  logic [4:0]  w_syn;
  logic [15:0] w_cnt_c, w_cnt_u;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dec_syndrome_corrector #(.CODE_WIDTH(32), .CORRECT_EN(1'b1), .CNT_WIDTH(16)) dut_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .codeword_with_errors(cw), .out_valid(m_out_valid), .out_ready(out_ready),
    .corrected_codeword(m_corr), .mul_result(m_syn), .err_single(m_single),
    .err_double(m_double), .cnt_clr(cnt_clr), .cnt_corr(m_cnt_c), .cnt_uncorr(m_cnt_u));

  dec_syndrome_corrector #(.CODE_WIDTH(32), .CORRECT_EN(1'b0), .CNT_WIDTH(16)) dut_nc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .codeword_with_errors(cw), .out_valid(n_out_valid), .out_ready(out_ready),
    .corrected_codeword(n_corr), .mul_result(n_syn), .err_single(n_single),
    .err_double(n_double), .cnt_clr(cnt_clr), .cnt_corr(n_cnt_c), .cnt_uncorr(n_cnt_u));

  dec_syndrome_corrector #(.CODE_WIDTH(32), .CORRECT_EN(1'b1), .CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .codeword_with_errors(cw), .out_valid(c_out_valid), .out_ready(out_ready),
    .corrected_codeword(c_corr), .mul_result(c_syn), .err_single(c_single),
    .err_double(c_double), .cnt_clr(cnt_clr), .cnt_corr(c_cnt_c), .cnt_uncorr(c_cnt_u));

  dec_syndrome_corrector #(.CODE_WIDTH(12), .CORRECT_EN(1'b1), .CNT_WIDTH(16)) dut_w12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .codeword_with_errors(cw[11:0]), .out_valid(w_out_valid), .out_ready(out_ready),
    .corrected_codeword(w_corr), .mul_result(w_syn), .err_single(w_single),
    .err_double(w_double), .cnt_clr(cnt_clr), .cnt_corr(w_cnt_c), .cnt_uncorr(w_cnt_u));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one word with out_ready high, check 2-cycle latency, result, then the drain cycle.
  task automatic send(input string tag, input logic [31:0] word, input logic [5:0] syn,
                      input logic [31:0] corr, input logic s, input logic d);
    in_valid = 1'b1;
    cw       = word;
    step();
    in_valid = 1'b0;
    check({tag, "/lat1"}, 64'(m_out_valid), 64'h0);
    step();
    check({tag, "/valid"},  64'(m_out_valid), 64'h1);
    check({tag, "/syn"},    64'(m_syn),       64'(syn));
    check({tag, "/corr"},   64'(m_corr),      64'(corr));
    check({tag, "/single"}, 64'(m_single),    64'(s));
    check({tag, "/double"}, 64'(m_double),    64'(d));
    step();
    check({tag, "/drain"},  64'(m_out_valid), 64'h0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    cw        = 32'h0;
    step();
    step();
    check("rst/out_valid", 64'(m_out_valid), 64'h0);
    check("rst/syn",       64'(m_syn),       64'h0);
    check("rst/corr",      64'(m_corr),      64'h0);
    check("rst/flags",     64'({m_single, m_double}), 64'h0);
    check("rst/cnt_corr",  64'(m_cnt_c),     64'h0);
    check("rst/cnt_unc",   64'(m_cnt_u),     64'h0);
    #4 rst = 1'b1;
    step();
    check("rst/in_ready",  64'(m_in_ready),  64'h1);

    send("clean", 32'hAAAAAAAA, 6'b000000, 32'hAAAAAAAA, 1'b0, 1'b0);
    check("clean/cnt_corr", 64'(m_cnt_c), 64'h0);

    send("bit5", 32'h00000020, 6'b100101, 32'h00000000, 1'b1, 1'b0);
    check("bit5/cnt_corr",   64'(m_cnt_c),  64'h1);
    check("bit5/c2_cnt",     64'(c_cnt_c),  64'h1);
    check("bit5/nc_single",  64'(n_single), 64'h1);
    check("bit5/nc_corr",    64'(n_corr),   64'h00000020);
    check("bit5/w12_syn",    64'(w_syn),    64'(5'b10101));
    check("bit5/w12_corr",   64'(w_corr),   64'h0);

    send("bit0", 32'h00000001, 6'b100000, 32'h00000000, 1'b1, 1'b0);
    check("bit0/cnt_corr", 64'(m_cnt_c), 64'h2);

    send("dbl", 32'h00000028, 6'b000110, 32'h00000028, 1'b0, 1'b1);
    check("dbl/cnt_unc",  64'(m_cnt_u), 64'h1);
    check("dbl/cnt_corr", 64'(m_cnt_c), 64'h2);

    send("bit31", 32'h80000000, 6'b111111, 32'h00000000, 1'b1, 1'b0);
    check("bit31/c2_cnt", 64'(c_cnt_c), 64'h3);

    send("tri", 32'h0000000E, 6'b100000, 32'h0000000F, 1'b1, 1'b0);
    send("bit3", 32'h00000007, 6'b100011, 32'h0000000F, 1'b1, 1'b0);
    check("sat/cnt_corr", 64'(m_cnt_c), 64'h5);
    check("sat/c2_cnt",   64'(c_cnt_c), 64'h3);
    check("bit3/nc_corr", 64'(n_corr),  64'h00000007);

    send("w12oor", 32'h00000212, 6'b101100, 32'h00001212, 1'b1, 1'b0);
    check("w12oor/syn",    64'(w_syn),    64'(5'b11100));
    check("w12oor/double", 64'(w_double), 64'h1);
    check("w12oor/single", 64'(w_single), 64'h0);
    check("w12oor/corr",   64'(w_corr),   64'h212);

    send("bit11", 32'h00000800, 6'b101011, 32'h00000000, 1'b1, 1'b0);
    check("w12top/syn",    64'(w_syn),    64'(5'b11011));
    check("w12top/single", 64'(w_single), 64'h1);
    check("w12top/corr",   64'(w_corr),   64'h0);
    check("bit11/cnt_corr", 64'(m_cnt_c), 64'h7);

    // Clear coinciding with a single-error transfer
    in_valid = 1'b1;
    cw       = 32'h00000020;
    step();
    in_valid = 1'b0;
    step();
    check("clr/single", 64'(m_single), 64'h1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr/cnt_corr", 64'(m_cnt_c), 64'h0);
    check("clr/c2_cnt",   64'(c_cnt_c), 64'h0);
    check("clr/cnt_unc",  64'(m_cnt_u), 64'h0);

    // Backpressure: four words, out_ready low for three cycles
    in_valid = 1'b1;
    cw       = 32'h00000020;
    step();
    cw        = 32'h00000028;
    out_ready = 1'b0;
    step();
    cw = 32'hAAAAAAAA;
    for (int k = 0; k < 3; k++) begin
      check("bp/held_valid", 64'(m_out_valid), 64'h1);
      check("bp/held_syn",   64'(m_syn),       64'(6'b100101));
      check("bp/held_corr",  64'(m_corr),      64'h0);
      check("bp/in_ready",   64'(m_in_ready),  64'h0);
      check("bp/cnt_corr",   64'(m_cnt_c),     64'h0);
      if (k == 2) begin
        out_ready = 1'b1;
      end else begin
        out_ready = 1'b0;
      end
      step();
    end
    check("bp/w1_syn",    64'(m_syn),    64'(6'b000110));
    check("bp/w1_double", 64'(m_double), 64'h1);
    cw = 32'h00000001;
    step();
    in_valid = 1'b0;
    check("bp/w2_syn",  64'(m_syn),  64'h0);
    check("bp/w2_corr", 64'(m_corr), 64'hAAAAAAAA);
    step();
    check("bp/w3_syn",   64'(m_syn),       64'(6'b100000));
    check("bp/w3_valid", 64'(m_out_valid), 64'h1);
    step();
    check("bp/drain",    64'(m_out_valid), 64'h0);
    check("bp/cnt_corr", 64'(m_cnt_c),     64'h2);
    check("bp/cnt_unc",  64'(m_cnt_u),     64'h1);

    // Reset with two words in flight
    in_valid = 1'b1;
    cw       = 32'h00000020;
    step();
    cw = 32'h00000028;
    step();
    in_valid = 1'b0;
    check("mid/pre_valid", 64'(m_out_valid), 64'h1);
    rst = 1'b0;
    #1;
    check("mid/out_valid", 64'(m_out_valid), 64'h0);
    check("mid/cnt_corr",  64'(m_cnt_c),     64'h0);
    check("mid/cnt_unc",   64'(m_cnt_u),     64'h0);
    step();
    #4 rst = 1'b1;
    step();
    check("mid/no_stale", 64'(m_out_valid), 64'h0);
    send("post", 32'h80000000, 6'b111111, 32'h00000000, 1'b1, 1'b0);
    check("post/cnt_corr", 64'(m_cnt_c), 64'h1);
    check("post/cnt_unc",  64'(m_cnt_u), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
